// File: rtl/stage_id_pkg.sv
// stage_id_pkg: shared definitions for the MIPS decode stage.
//   - primary opcode constants
//   - ALU operation encodings passed to EX
//   - ID/EX control bundle and per-opcode decode helper
//   - NOP instruction word (sll $0,$0,0)
package stage_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSub   = 3'b001,
        AluFunct = 3'b010,
        AluAnd   = 3'b011,
        AluOr    = 3'b100,
        AluSlt   = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        ctrl_t ctrl;
        logic  is_beq;
        logic  is_bne;
        logic  is_j;
        logic  uses_rt;   // rt is a source operand (load-use check)
        logic  zero_ext;  // logical immediates are zero-extended
    } decode_t;

    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d = '0;
        unique case (op)
            OP_RTYPE: begin
                d.ctrl.reg_dst   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = AluFunct;
                d.uses_rt        = 1'b1;
            end
            OP_LW: begin
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl.alu_op = AluSub;
                d.is_beq      = 1'b1;
                d.uses_rt     = 1'b1;
            end
            OP_BNE: begin
                d.ctrl.alu_op = AluSub;
                d.is_bne      = 1'b1;
                d.uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = AluAnd;
                d.zero_ext       = 1'b1;
            end
            OP_ORI: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = AluOr;
                d.zero_ext       = 1'b1;
            end
            OP_SLTI: begin
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = AluSlt;
            end
            OP_J: begin
                d.is_j = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stage_id_if.sv
// stage_id_if: bundle between the decode stage and the rest of the pipeline.
//   Inputs to ID : IF/ID latch, WB write port, EX/MEM hazard info, MEM ALU result.
//   Outputs of ID: fetch controls (branch target, PCSrc, Jump, PCWrite, IF_IDWrite,
//                  IF_Flush) and the ID/EX latch contents.
//   slave  : view used by stage_id.
//   master : view used by the surrounding pipeline / testbench.
interface stage_id_if #(
    parameter int unsigned DW = 32
);
    logic [31:0]   inInstruction;
    logic [DW-1:0] inPostPc;
    logic          inRegWriteWb;
    logic [4:0]    inWriteRegWb;
    logic [DW-1:0] inWriteDataWb;
    logic          inMemReadEx;
    logic          inRegWriteEx;
    logic [4:0]    inWriteRegEx;
    logic          inMemReadMem;
    logic          inRegWriteMem;
    logic [4:0]    inWriteRegMem;
    logic [DW-1:0] inAluResultMem;

    logic [DW-1:0] outAddId;
    logic          PCSrc;
    logic          Jump;
    logic          outPCWrite;
    logic          outIF_IDWrite;
    logic          outIF_Flush;
    logic [DW-1:0] outReadData1;
    logic [DW-1:0] outReadData2;
    logic [DW-1:0] outSignExt;
    logic [4:0]    outRs;
    logic [4:0]    outRt;
    logic [4:0]    outRd;
    logic [DW-1:0] outPostPc;
    logic          outRegDst;
    logic          outAluSrc;
    logic          outMemRead;
    logic          outMemWrite;
    logic          outMemToReg;
    logic          outRegWrite;
    logic [2:0]    outAluOp;

    modport slave (
        input  inInstruction, inPostPc, inRegWriteWb, inWriteRegWb, inWriteDataWb,
        input  inMemReadEx, inRegWriteEx, inWriteRegEx,
        input  inMemReadMem, inRegWriteMem, inWriteRegMem, inAluResultMem,
        output outAddId, PCSrc, Jump, outPCWrite, outIF_IDWrite, outIF_Flush,
        output outReadData1, outReadData2, outSignExt, outRs, outRt, outRd, outPostPc,
        output outRegDst, outAluSrc, outMemRead, outMemWrite, outMemToReg, outRegWrite,
        output outAluOp
    );

    modport master (
        output inInstruction, inPostPc, inRegWriteWb, inWriteRegWb, inWriteDataWb,
        output inMemReadEx, inRegWriteEx, inWriteRegEx,
        output inMemReadMem, inRegWriteMem, inWriteRegMem, inAluResultMem,
        input  outAddId, PCSrc, Jump, outPCWrite, outIF_IDWrite, outIF_Flush,
        input  outReadData1, outReadData2, outSignExt, outRs, outRt, outRd, outPostPc,
        input  outRegDst, outAluSrc, outMemRead, outMemWrite, outMemToReg, outRegWrite,
        input  outAluOp
    );

endinterface

// File: rtl/stage_id_reg_file.sv
// stage_id_reg_file: 2-read / 1-write register file.
//   i_clk, i_reset      : clock, synchronous active-high clear of all registers
//   i_raddr1/2, o_rdata1/2 : combinational read ports
//   i_we, i_waddr, i_wdata : write port, committed on the rising edge
// Register 0 reads as zero and is never written. A read of the address being
// written this cycle returns the write data so WB->ID needs no extra cycle.
module stage_id_reg_file #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_regs [NREG];
    logic          w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
        if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
        if (i_raddr1 == '0) o_rdata1 = '0;
        if (i_raddr2 == '0) o_rdata2 = '0;
    end

endmodule

// File: rtl/stage_id.sv
// stage_id: decode stage of the 5-stage MIPS pipeline.
//   clk, reset : single rising-edge clock, synchronous active-high reset
//   io_bus     : stage_id_if.slave
//     - IF/ID inputs (instruction, PC+4), WB write port, EX/MEM hazard info
//     - combinational fetch controls: outAddId, PCSrc, Jump, outPCWrite,
//       outIF_IDWrite, outIF_Flush
//     - registered ID/EX latch: operands, immediate, register fields, PC+4, control
// beq/bne/j resolve here; branch operands come from the register file or are
// forwarded from a non-load ALU result in MEM.
module stage_id
    import stage_id_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic       clk,
    input  logic       reset,
    stage_id_if.slave  io_bus
);

    logic [5:0]    w_opcode;
    logic [4:0]    w_rs;
    logic [4:0]    w_rt;
    logic [4:0]    w_rd;
    logic [15:0]   w_imm;
    decode_t       w_dec;
    logic [DW-1:0] w_rdata1;
    logic [DW-1:0] w_rdata2;
    logic [DW-1:0] w_imm_sext;
    logic [DW-1:0] w_imm_ext;

    assign w_opcode = io_bus.inInstruction[31:26];
    assign w_rs     = io_bus.inInstruction[25:21];
    assign w_rt     = io_bus.inInstruction[20:16];
    assign w_rd     = io_bus.inInstruction[15:11];
    assign w_imm    = io_bus.inInstruction[15:0];
    assign w_dec    = decode_op(w_opcode);

    stage_id_reg_file #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (5)
    ) u_reg_file (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (io_bus.inRegWriteWb),
        .i_waddr  (io_bus.inWriteRegWb),
        .i_wdata  (io_bus.inWriteDataWb)
    );

    // Branch target always uses the sign-extended offset; only the ID/EX
    // immediate honours zero extension for andi/ori.
    assign w_imm_sext = {{(DW-16){w_imm[15]}}, w_imm};
    assign w_imm_ext  = w_dec.zero_ext ? {{(DW-16){1'b0}}, w_imm} : w_imm_sext;
    assign io_bus.outAddId = io_bus.inPostPc + (w_imm_sext << 2);

    // Hazard detection
    logic w_is_branch;
    logic w_load_use;
    logic w_ex_hit_rs, w_ex_hit_rt;
    logic w_mem_ld_hit_rs, w_mem_ld_hit_rt;
    logic w_branch_stall;
    logic w_stall;

    assign w_is_branch = w_dec.is_beq || w_dec.is_bne;

    assign w_load_use = io_bus.inMemReadEx &&
                        ((io_bus.inWriteRegEx == w_rs) ||
                         (w_dec.uses_rt && (io_bus.inWriteRegEx == w_rt)));

    assign w_ex_hit_rs = io_bus.inRegWriteEx && (io_bus.inWriteRegEx != 5'd0) &&
                         (io_bus.inWriteRegEx == w_rs);
    assign w_ex_hit_rt = io_bus.inRegWriteEx && (io_bus.inWriteRegEx != 5'd0) &&
                         (io_bus.inWriteRegEx == w_rt);
    assign w_mem_ld_hit_rs = io_bus.inMemReadMem && (io_bus.inWriteRegMem != 5'd0) &&
                             (io_bus.inWriteRegMem == w_rs);
    assign w_mem_ld_hit_rt = io_bus.inMemReadMem && (io_bus.inWriteRegMem != 5'd0) &&
                             (io_bus.inWriteRegMem == w_rt);

    assign w_branch_stall = w_is_branch &&
                            (w_ex_hit_rs || w_ex_hit_rt || w_mem_ld_hit_rs || w_mem_ld_hit_rt);
    assign w_stall = w_load_use || w_branch_stall;

    // Branch comparator with MEM ALU-result forwarding
    logic          w_fwd_ok;
    logic [DW-1:0] w_cmp_a;
    logic [DW-1:0] w_cmp_b;
    logic          w_equal;
    logic          w_taken;

    assign w_fwd_ok = io_bus.inRegWriteMem && !io_bus.inMemReadMem &&
                      (io_bus.inWriteRegMem != 5'd0);
    assign w_cmp_a  = (w_fwd_ok && (io_bus.inWriteRegMem == w_rs)) ? io_bus.inAluResultMem
                                                                   : w_rdata1;
    assign w_cmp_b  = (w_fwd_ok && (io_bus.inWriteRegMem == w_rt)) ? io_bus.inAluResultMem
                                                                   : w_rdata2;
    assign w_equal  = (w_cmp_a == w_cmp_b);
    assign w_taken  = (w_dec.is_beq && w_equal) || (w_dec.is_bne && !w_equal);

    // Fetch controls; reset overrides stall, stall overrides redirect.
    always_comb begin
        io_bus.PCSrc         = 1'b0;
        io_bus.Jump          = 1'b0;
        io_bus.outPCWrite    = 1'b1;
        io_bus.outIF_IDWrite = 1'b1;
        io_bus.outIF_Flush   = 1'b0;
        if (reset) begin
            io_bus.outIF_Flush = 1'b1;
        end else if (w_stall) begin
            io_bus.outPCWrite    = 1'b0;
            io_bus.outIF_IDWrite = 1'b0;
        end else begin
            if (w_taken) begin
                io_bus.PCSrc       = 1'b1;
                io_bus.outIF_Flush = 1'b1;
            end
            if (w_dec.is_j) begin
                io_bus.Jump        = 1'b1;
                io_bus.outIF_Flush = 1'b1;
            end
        end
    end

    // ID/EX latch: a stall injects a bubble in control but data still loads.
    ctrl_t         r_ctrl;
    logic [DW-1:0] r_read_data1;
    logic [DW-1:0] r_read_data2;
    logic [DW-1:0] r_sign_ext;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_rd;
    logic [DW-1:0] r_post_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl       <= CTRL_NOP;
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_sign_ext   <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_post_pc    <= '0;
        end else begin
            r_ctrl       <= w_stall ? CTRL_NOP : w_dec.ctrl;
            r_read_data1 <= w_rdata1;
            r_read_data2 <= w_rdata2;
            r_sign_ext   <= w_imm_ext;
            r_rs         <= w_rs;
            r_rt         <= w_rt;
            r_rd         <= w_rd;
            r_post_pc    <= io_bus.inPostPc;
        end
    end

    assign io_bus.outReadData1 = r_read_data1;
    assign io_bus.outReadData2 = r_read_data2;
    assign io_bus.outSignExt   = r_sign_ext;
    assign io_bus.outRs        = r_rs;
    assign io_bus.outRt        = r_rt;
    assign io_bus.outRd        = r_rd;
    assign io_bus.outPostPc    = r_post_pc;
    assign io_bus.outRegDst    = r_ctrl.reg_dst;
    assign io_bus.outAluSrc    = r_ctrl.alu_src;
    assign io_bus.outMemRead   = r_ctrl.mem_read;
    assign io_bus.outMemWrite  = r_ctrl.mem_write;
    assign io_bus.outMemToReg  = r_ctrl.mem_to_reg;
    assign io_bus.outRegWrite  = r_ctrl.reg_write;
    assign io_bus.outAluOp     = r_ctrl.alu_op;

endmodule
